// File: rtl/button_debounce.sv
// Push-button synchronizer and debouncer: emits one registered single-clock pulse
// for each accepted press; releases only re-arm the block.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic button_in,
  output logic button_out
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   sync_in;
  logic                   stable_q;
  logic                   stable_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   button_out_q;
  logic                   button_out_d;

  // button_in is sampled only by the first stage of this chain
  assign sync_d[0] = button_in;
  generate
    for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
      assign sync_d[gi] = sync_q[gi-1];
    end
  endgenerate

  assign sync_in = sync_q[SYNC_STAGES-1];

  always_comb begin
    stable_d     = stable_q;
    cnt_d        = cnt_q;
    button_out_d = 1'b0;
    if (sync_in == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      // Full window of disagreement: accept the new level; only a rise pulses
      stable_d     = sync_in;
      cnt_d        = '0;
      button_out_d = sync_in;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q       <= '0;
      stable_q     <= 1'b0;
      cnt_q        <= '0;
      button_out_q <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      stable_q     <= stable_d;
      cnt_q        <= cnt_d;
      button_out_q <= button_out_d;
    end
  end

  assign button_out = button_out_q;

endmodule

// File: tb/tb_button_debounce.sv
// Randomized and directed bench for button_debounce, checked every cycle against
// a sliding-window model of the delayed button samples.
module tb_button_debounce;

  localparam int DC = 4;
  localparam int SS = 2;

  logic clk;
  logic reset;
  logic button_in;
  logic button_out;

  int n_checks;
  int n_errors;
  int edge_n;
  int pulse_cnt;
  int pulse_edge;

  // Model state: raw samples since reset (prefilled with the cleared synchronizer)
  // and the history of synchronized samples the debouncer has evaluated.
  bit raw_q[$];
  bit samp_q[$];
  bit exp_stable;
  bit exp_pulse;

  button_debounce #(.DEBOUNCE_CYCLES(DC), .SYNC_STAGES(SS)) dut (
    .clk       (clk),
    .reset     (reset),
    .button_in (button_in),
    .button_out(button_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  // A level is accepted when the last DC synchronized samples all disagree with it.
  task automatic model_edge(input bit b, input bit r);
    bit all_diff;
    exp_pulse = 1'b0;
    if (!r) begin
      raw_q.delete();
      for (int i = 0; i < SS; i++) raw_q.push_back(1'b0);
      samp_q.delete();
      exp_stable = 1'b0;
    end else begin
      raw_q.push_back(b);
      samp_q.push_back(raw_q[raw_q.size() - 1 - SS]);
      if (samp_q.size() >= DC) begin
        all_diff = 1'b1;
        for (int i = 0; i < DC; i++)
          if (samp_q[samp_q.size() - 1 - i] == exp_stable) all_diff = 1'b0;
        if (all_diff) begin
          exp_stable = ~exp_stable;
          exp_pulse  = exp_stable;
        end
      end
    end
  endtask

  task automatic tick(input bit b, input bit r);
    button_in = b;
    reset     = r;
    @(posedge clk);
    edge_n++;
    model_edge(b, r);
    @(negedge clk);
    check("out", button_out, exp_pulse);
    if (button_out === 1'b1) begin
      pulse_cnt++;
      pulse_edge = edge_n;
    end
  endtask

  task automatic ticks(input bit b, input bit r, input int n);
    for (int i = 0; i < n; i++) tick(b, r);
  endtask

  initial begin
    int e;
    int lvl;
    int len;
    n_checks   = 0;
    n_errors   = 0;
    edge_n     = 0;
    pulse_cnt  = 0;
    pulse_edge = -1;
    exp_stable = 1'b0;
    exp_pulse  = 1'b0;
    button_in  = 1'b0;
    reset      = 1'b0;

    // Reset held with the button pressed, then released
    ticks(1, 0, 3);
    check("reset_pulses", pulse_cnt, 0);
    e = edge_n + 1;
    pulse_cnt = 0;
    ticks(1, 1, 12);
    check("reset_release_cnt", pulse_cnt, 1);
    check("reset_release_edge", pulse_edge, e + 5);
    pulse_cnt = 0;
    ticks(0, 1, 10);
    check("release1_cnt", pulse_cnt, 0);

    // Clean press
    e = edge_n + 1;
    ticks(1, 1, 20);
    check("clean_cnt", pulse_cnt, 1);
    check("clean_edge", pulse_edge, e + 5);
    pulse_cnt = 0;
    ticks(0, 1, 10);
    check("release2_cnt", pulse_cnt, 0);

    // Bounce before a steady press
    ticks(1, 1, 2); ticks(0, 1, 1); ticks(1, 1, 3); ticks(0, 1, 1);
    e = edge_n + 1;
    ticks(1, 1, 15);
    check("bounce_cnt", pulse_cnt, 1);
    check("bounce_edge", pulse_edge, e + 5);
    pulse_cnt = 0;
    ticks(0, 1, 10);

    // Short glitch
    ticks(1, 1, 3);
    ticks(0, 1, 12);
    check("glitch_cnt", pulse_cnt, 0);
    check("glitch_stable", dut.stable_q, 0);

    // Repeated presses
    ticks(1, 1, 10); ticks(0, 1, 10); ticks(1, 1, 10); ticks(0, 1, 10);
    check("repeat_cnt", pulse_cnt, 2);
    pulse_cnt = 0;

    // Reset in the middle of a debounce window
    ticks(1, 1, 4);
    check("mid_cnt_value", dut.cnt_q, 2);
    tick(1, 0);
    check("mid_abort_cnt", pulse_cnt, 0);
    e = edge_n + 1;
    ticks(1, 1, 12);
    check("mid_fresh_cnt", pulse_cnt, 1);
    check("mid_fresh_edge", pulse_edge, e + 5);
    ticks(0, 1, 10);

    // Random bouncy segments with occasional resets
    for (int s = 0; s < 400; s++) begin
      lvl = $urandom_range(0, 1);
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 12) : $urandom_range(1, 5);
      for (int i = 0; i < len; i++)
        tick(lvl[0], ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
# button_debounce

Debounces and synchronizes one raw mechanical push-button input. Emits a single-clock pulse for each accepted press. Sits between a board pushbutton pin and control logic that must advance exactly once per press, for example a level/address advance in a game controller. The output is fully registered and safe to use directly as a clock-enable in the `clk` domain.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000, is the number of consecutive clocks the synchronized input must differ from the accepted state before a change is accepted.
  - The default is 10 ms at 100 MHz.
  - Legal range is ≥ 1.
- `SYNC_STAGES`, default 2, is the number of synchronizer flops on `button_in`. Legal range is ≥ 2.

Ports:
- `clk` input 1: the single system clock. All logic is on the rising edge.
- `reset` input 1: reset is synchronous and active-low. One clock; `reset` = 0 at a rising edge of `clk` resets the block.
- `button_in` input 1: raw, asynchronous, bouncing button level. 1 = pressed.
- `button_out` input/output: output 1. It is a one-clock pulse, active high, issued when a press is accepted.

## Operation
Synchronizer:
- `button_in` passes through a chain of `SYNC_STAGES` flops.
- The last stage is `sync_in`.
- No other logic samples `button_in`.

Accepted state `stable`:
- 1 bit, reset value 0.

Counter `cnt`:
- Width is ceil(log2(`DEBOUNCE_CYCLES`)), minimum 1 bit.
- Reset value 0.

Every clock when not in reset:
- If `sync_in` == `stable`, then `cnt` <= 0, because any agreement restarts the debounce window.
- Else, if `cnt` == `DEBOUNCE_CYCLES`-1:
  - `stable` <= `sync_in`.
  - `cnt` <= 0.
- Otherwise `cnt` <= `cnt`+1.
- `cnt` never wraps. It is cleared before reaching `DEBOUNCE_CYCLES`.

Output:
- `button_out` <= 1 only on the clock where `stable` changes 0→1; otherwise 0.
- A 1→0 acceptance (release) produces no pulse. It only re-arms the block.
- A held button produces exactly one pulse, regardless of hold length.
- A second pulse requires an accepted release followed by an accepted press.

Reset (`reset` = 0):
- All synchronizer flops, `stable`, `cnt` and `button_out` are set to 0 on that edge.
- Reset has priority over all other activity and can abort a debounce window in progress.
- If the button is held across reset release, it is treated as a new press: one pulse after the full latency.

## Timing
Press latency, with k the first rising edge at which `button_in` = 1 and stays 1:
- `button_out` is 1 in the cycle after edge k+`SYNC_STAGES`+`DEBOUNCE_CYCLES`-1.
- It is 0 again after the following edge.
- With the defaults, `SYNC_STAGES`=2 gives edge k+`DEBOUNCE_CYCLES`+1.

Release latency is the same formula for `stable` falling. `button_out` stays 0 throughout.

Glitch rejection:
- Any deviation shorter than `DEBOUNCE_CYCLES` clocks at `sync_in` is ignored.
- Bounce that returns to the accepted level restarts the count from 0.

Pulse width:
- `button_out` is high for exactly 1 clock per accepted press.
- There is never a back-to-back high, since `stable` cannot re-rise without first falling and being accepted.

No handshake; `button_out` is not held pending a consumer.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `SYNC_STAGES`=2.
- Reset:
  - Hold `reset`=0 for 3 clocks with `button_in`=1. `button_out`=0 throughout.
  - Then release reset. `button_out` pulses once, 5 edges after the first edge with `reset`=1.
- Clean press:
  - `button_in` goes 0→1 before edge k and is held for 20 clocks.
  - `button_out`=1 only in the cycle after edge k+5, and 0 everywhere else.
- Bounce:
  - Drive `button_in` as 1 for 2 clocks, 0 for 1, 1 for 3, 0 for 1, then 1 steady from edge m.
  - Exactly one pulse, in the cycle after edge m+5. No earlier pulse.
- Short glitch: `button_in` high for 3 clocks, then low. `button_out` never asserts and `stable` stays 0.
- Repeated presses:
  - Press for 10 clocks, release for 10, press for 10.
  - Exactly two single-clock pulses, with no pulse on either release.
- Reset mid-window:
  - Assert `reset`=0 while `cnt`=2 during a press.
  - No pulse from the aborted window. After reset release, a fresh full-latency pulse occurs if the button is still held.
